// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared state encoding and width limits for the bit-serial subtractor controller.
package serial_subtractor_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result handshake bundle; master is the producer/consumer side, slave is the controller.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, Ovf
  );

endinterface

// File: rtl/serial_subtractor_ctrl_fs_bit_cell.sv
// 1-bit full subtractor: d = a - b - bin, bout set when the bit step needs a borrow.
// Purely combinational, zero latency, no handshake.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - Bin, LSB first; result valid WIDTH edges after accept, held until out_ready.
// Accepts only in IDLE; no bypass from DONE straight into RUN.
import serial_subtractor_ctrl_pkg::*;

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_ctrl_if.slave bus,
  output logic                    busy
);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("serial_subtractor_ctrl: WIDTH must be within 1..32");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_next;
  logic [WIDTH-1:0]   diff_q;
  logic [CNT_W-1:0]   cnt;
  logic               borrow_q;
  logic               bout_q;
  logic               ovf_q;
  logic               a_msb;
  logic               b_msb;
  logic               d;
  logic               bo;
  logic               last;

  fs_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_q),
    .d    (d),
    .bout (bo)
  );

  // Shift-based form keeps WIDTH=1 legal (no zero-width slices).
  assign r_next = (r_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            r_sh     <= '0;
            borrow_q <= bus.Bin;
            cnt      <= '0;
            a_msb    <= bus.A[WIDTH-1];
            b_msb    <= bus.B[WIDTH-1];
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          r_sh     <= r_next;
          borrow_q <= bo;
          cnt      <= cnt + CNT_W'(1);
          // Final step: d is the result MSB, so overflow is decided here.
          if (last) begin
            diff_q <= r_next;
            bout_q <= bo;
            ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ d);
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;
  assign bus.Ovf       = ovf_q;
  assign busy          = (state == RUN);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomized bench for serial_subtractor_ctrl against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

  localparam int WIDTH = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk;
  logic rst_n;
  logic busy;

  int vectors;
  int miscompares;

  serial_subtractor_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed meanings.
  task automatic model(input int a, input int b, input int bin,
                       output int diff, output int bout, output int ovf);
    int sa, sb, sres;
    diff = (a - b - bin) & MASK;
    bout = (a < b + bin) ? 1 : 0;
    sa   = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
    sb   = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
    sres = sa - sb - bin;
    ovf  = (sres < -(1 << (WIDTH - 1)) || sres > (1 << (WIDTH - 1)) - 1) ? 1 : 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(bus.Diff), 32'd0);
    check({tag, "_bout"}, 32'(bus.Bout), 32'd0);
    check({tag, "_ovf"}, 32'(bus.Ovf), 32'd0);
  endtask

  // One full transaction: accept, latency count, stalled hold, release.
  task automatic run_op(input int a, input int b, input int bin, input int stall,
                        input bit poke_in_valid, input bit detailed);
    int exp_diff, exp_bout, exp_ovf;
    int lat;
    model(a, b, bin, exp_diff, exp_bout, exp_ovf);
    @(negedge clk);
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.A        = WIDTH'(a);
    bus.B        = WIDTH'(b);
    bus.Bin      = bin[0];
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = WIDTH'($urandom);
    bus.B        = WIDTH'($urandom);
    bus.Bin      = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (detailed) begin
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(WIDTH));
    check("diff", 32'(bus.Diff), 32'(exp_diff));
    check("bout", 32'(bus.Bout), 32'(exp_bout));
    check("ovf", 32'(bus.Ovf), 32'(exp_ovf));
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = poke_in_valid;
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_diff", 32'(bus.Diff), 32'(exp_diff));
      check("hold_flags", {30'd0, bus.Bout, bus.Ovf}, 32'({exp_bout[0], exp_ovf[0]}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_diff_kept", 32'(bus.Diff), 32'(exp_diff));
  endtask

  initial begin
    int seen_valid;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 0, 0, 1'b0, 1'b1);
    run_op(8'h00, 8'h01, 0, 0, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1, 0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 0, 0, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 0, 5, 1'b1, 1'b1);

    // Abort mid-run: after three bit steps the counter sits at 3.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 8'hC3;
    bus.B        = 8'h11;
    bus.Bin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrun_reset");
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1;
    end
    check("midrun_no_valid", 32'(seen_valid), 32'd0);
    run_op(8'h10, 8'h01, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
             1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
